// File: rtl/tile_pkg.sv
// Shared types and elaboration helpers for the complex tile buffer and its RAM.
package tile_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_t;

    function automatic int unsigned beats_f(input int unsigned tile, input int unsigned lanes);
        return (tile * tile) / lanes;
    endfunction

    // True when a tile splits into a whole number of write beats.
    function automatic bit lanes_divide_f(input int unsigned tile, input int unsigned lanes);
        return (lanes != 0) && (((tile * tile) % lanes) == 0);
    endfunction

endpackage

// File: rtl/complex_sdp_ram.sv
// Simple dual-port RAM: each word is BEATS sub-blocks of LANES complex_t, written
// one sub-block at a time and read back as a whole word with one cycle of latency.
module complex_sdp_ram
    import tile_pkg::*;
#(
    parameter int unsigned LANES  = 8,
    parameter int unsigned BEATS  = 2,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [BEATS-1:0]                 i_we,
    input  logic [ADDR_W-1:0]                i_waddr,
    input  complex_t [0:LANES-1]             i_wdata,
    input  logic                             i_re,
    input  logic [ADDR_W-1:0]                i_raddr,
    output complex_t [0:BEATS-1][0:LANES-1]  o_rdata
);

    complex_t [0:LANES-1]             r_mem [0:(2**ADDR_W)-1][0:BEATS-1];
    complex_t [0:BEATS-1][0:LANES-1]  r_rdata;

    always_ff @(posedge i_clk) begin
        for (int unsigned b = 0; b < BEATS; b++) begin
            if (i_we[b]) begin
                r_mem[i_waddr][b] <= i_wdata;
            end
        end
    end

    // Only the read register is reset; the array keeps its contents.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
                r_rdata[b] <= r_mem[i_raddr][b];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/complex_tile_buffer.sv
// Ping-pong tile buffer: assembles WR_LANES-wide beats into TILE x TILE tiles in one
// bank while the reader serves whole tiles from the other, with handshaked ownership.
module complex_tile_buffer
    import tile_pkg::*;
#(
    parameter int unsigned TILE       = 4,
    parameter int unsigned WR_LANES   = 8,
    parameter int unsigned DEPTH_BITS = 9
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_wr_valid,
    output logic                             o_wr_ready,
    input  complex_t [0:WR_LANES-1]          i_wr_data,
    input  logic                             i_wr_last,
    output logic                             o_rd_bank_ready,
    output logic [DEPTH_BITS:0]              o_rd_tiles,
    input  logic                             i_rd_en,
    input  logic [DEPTH_BITS-1:0]            i_rd_addr,
    output logic                             o_rd_valid,
    output complex_t [0:TILE-1][0:TILE-1]    o_rd_data,
    input  logic                             i_rd_release
);

    localparam int unsigned BEATS  = beats_f(TILE, WR_LANES);
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [DEPTH_BITS-1:0] LAST_TILE = '1;

    if (!lanes_divide_f(TILE, WR_LANES)) begin : g_bad_lanes
        $error("complex_tile_buffer: WR_LANES must divide TILE*TILE");
    end

    logic [1:0]                  r_full;
    logic [1:0][DEPTH_BITS:0]    r_count;
    logic                        r_wr_bank;
    logic                        r_rd_bank;
    logic [BEAT_W-1:0]           r_beat;
    logic [DEPTH_BITS-1:0]       r_tile;
    logic                        r_rd_valid;

    logic                        w_wr_acc;
    logic                        w_final_beat;
    logic                        w_commit;
    logic                        w_rd_acc;
    logic                        w_release;
    logic [BEATS-1:0]            w_we;
    complex_t [0:BEATS-1][0:WR_LANES-1] w_ram_rdata;

    assign w_wr_acc     = i_wr_valid && !r_full[r_wr_bank];
    assign w_final_beat = (r_beat == LAST_BEAT);
    assign w_commit     = w_wr_acc && w_final_beat && (i_wr_last || (r_tile == LAST_TILE));
    assign w_rd_acc     = i_rd_en && r_full[r_rd_bank]
                          && ({1'b0, i_rd_addr} < r_count[r_rd_bank]);
    assign w_release    = i_rd_release && r_full[r_rd_bank];

    always_comb begin
        w_we = '0;
        if (w_wr_acc) begin
            w_we[r_beat] = 1'b1;
        end
    end

    // Commit needs an empty write bank and release a full read bank, so the two
    // full-flag updates in one cycle always land on different banks.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_full     <= '0;
            r_count    <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_beat     <= '0;
            r_tile     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                if (w_final_beat) begin
                    r_beat <= '0;
                    if (w_commit) begin
                        r_full[r_wr_bank]  <= 1'b1;
                        r_count[r_wr_bank] <= {1'b0, r_tile} + (DEPTH_BITS + 1)'(1);
                        r_tile             <= '0;
                        r_wr_bank          <= ~r_wr_bank;
                    end else begin
                        r_tile <= r_tile + DEPTH_BITS'(1);
                    end
                end else begin
                    r_beat <= r_beat + BEAT_W'(1);
                end
            end
            if (w_release) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
            r_rd_valid <= w_rd_acc;
        end
    end

    complex_sdp_ram #(
        .LANES  (WR_LANES),
        .BEATS  (BEATS),
        .ADDR_W (DEPTH_BITS + 1)
    ) u_ram (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (w_we),
        .i_waddr ({r_wr_bank, r_tile}),
        .i_wdata (i_wr_data),
        .i_re    (w_rd_acc),
        .i_raddr ({r_rd_bank, i_rd_addr}),
        .o_rdata (w_ram_rdata)
    );

    // Element e sits at beat e/WR_LANES, lane e%WR_LANES and at row e/TILE, col e%TILE.
    always_comb begin
        o_rd_data = '0;
        for (int unsigned e = 0; e < TILE * TILE; e++) begin
            o_rd_data[e / TILE][e % TILE] = w_ram_rdata[e / WR_LANES][e % WR_LANES];
        end
    end

    assign o_wr_ready      = !r_full[r_wr_bank];
    assign o_rd_bank_ready = r_full[r_rd_bank];
    assign o_rd_tiles      = r_count[r_rd_bank];
    assign o_rd_valid      = r_rd_valid;

endmodule

// File: tb/tb_complex_tile_buffer.sv
// Bench for complex_tile_buffer: frame-level reference model with per-cycle compare,
// plus directed literal checks, and a TILE=8 / WR_LANES=16 instance for lane mapping.
module tb_complex_tile_buffer;
    import tile_pkg::*;

    localparam int T     = 4;
    localparam int WL    = 8;
    localparam int DB    = 9;
    localparam int CAP   = 512;
    localparam int BEATS = 2;

    localparam int T2  = 8;
    localparam int WL2 = 16;
    localparam int DB2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         reset, wr_valid, wr_ready, wr_last;
    complex_t [0:WL-1]            wr_data;
    logic                         rd_bank_ready, rd_en, rd_valid, rd_release;
    logic [DB:0]                  rd_tiles;
    logic [DB-1:0]                rd_addr;
    complex_t [0:T-1][0:T-1]      rd_data;

    logic                         b_reset, b_wr_valid, b_wr_ready, b_wr_last;
    complex_t [0:WL2-1]           b_wr_data;
    logic                         b_rd_bank_ready, b_rd_en, b_rd_valid, b_rd_release;
    logic [DB2:0]                 b_rd_tiles;
    logic [DB2-1:0]               b_rd_addr;
    complex_t [0:T2-1][0:T2-1]    b_rd_data;

    complex_tile_buffer #(.TILE(T), .WR_LANES(WL), .DEPTH_BITS(DB)) dut (
        .i_clk(clk), .i_reset(reset), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
        .i_wr_data(wr_data), .i_wr_last(wr_last), .o_rd_bank_ready(rd_bank_ready),
        .o_rd_tiles(rd_tiles), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_valid(rd_valid), .o_rd_data(rd_data), .i_rd_release(rd_release)
    );

    complex_tile_buffer #(.TILE(T2), .WR_LANES(WL2), .DEPTH_BITS(DB2)) dut_wide (
        .i_clk(clk), .i_reset(b_reset), .i_wr_valid(b_wr_valid), .o_wr_ready(b_wr_ready),
        .i_wr_data(b_wr_data), .i_wr_last(b_wr_last), .o_rd_bank_ready(b_rd_bank_ready),
        .o_rd_tiles(b_rd_tiles), .i_rd_en(b_rd_en), .i_rd_addr(b_rd_addr),
        .o_rd_valid(b_rd_valid), .o_rd_data(b_rd_data), .i_rd_release(b_rd_release)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: two banks of frames held as [tile][row][col] arrays.
    complex_t                 m_mem [0:2*CAP-1][0:T-1][0:T-1];
    logic                     m_full [2];
    int                       m_count [2];
    int                       m_wr_bank, m_rd_bank, m_beat, m_tile;
    logic                     m_rd_valid;
    complex_t [0:T-1][0:T-1]  m_rd_data;
    logic                     cmp_en = 1'b0;

    logic mdl_wr_acc, mdl_rd_acc, mdl_rel;
    assign mdl_wr_acc = wr_valid && !m_full[m_wr_bank];
    assign mdl_rd_acc = rd_en && m_full[m_rd_bank] && (int'(rd_addr) < m_count[m_rd_bank]);
    assign mdl_rel    = rd_release && m_full[m_rd_bank];

    always @(posedge clk) begin
        if (reset) begin
            m_full[0] <= 1'b0; m_full[1] <= 1'b0;
            m_count[0] <= 0;   m_count[1] <= 0;
            m_wr_bank <= 0; m_rd_bank <= 0; m_beat <= 0; m_tile <= 0;
            m_rd_valid <= 1'b0;
            m_rd_data  <= '0;
        end else begin
            if (mdl_wr_acc) begin
                for (int l = 0; l < WL; l++) begin
                    m_mem[m_wr_bank*CAP + m_tile][(m_beat*WL + l) / T][(m_beat*WL + l) % T] <= wr_data[l];
                end
                if (m_beat == BEATS - 1) begin
                    m_beat <= 0;
                    if (wr_last || m_tile == CAP - 1) begin
                        m_full[m_wr_bank]  <= 1'b1;
                        m_count[m_wr_bank] <= m_tile + 1;
                        m_tile             <= 0;
                        m_wr_bank          <= 1 - m_wr_bank;
                    end else begin
                        m_tile <= m_tile + 1;
                    end
                end else begin
                    m_beat <= m_beat + 1;
                end
            end
            if (mdl_rel) begin
                m_full[m_rd_bank] <= 1'b0;
                m_rd_bank         <= 1 - m_rd_bank;
            end
            m_rd_valid <= mdl_rd_acc;
            if (mdl_rd_acc) begin
                for (int r = 0; r < T; r++) begin
                    for (int c = 0; c < T; c++) begin
                        m_rd_data[r][c] <= m_mem[m_rd_bank*CAP + int'(rd_addr)][r][c];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_wr_ready", 64'(wr_ready), 64'(!m_full[m_wr_bank]));
            chk("cmp_rd_bank_ready", 64'(rd_bank_ready), 64'(m_full[m_rd_bank]));
            chk("cmp_rd_tiles", 64'(rd_tiles), 64'(m_count[m_rd_bank]));
            chk("cmp_rd_valid", 64'(rd_valid), 64'(m_rd_valid));
            checks++;
            if (rd_data !== m_rd_data) begin
                errors++;
                $display("FAIL cmp_rd_data actual=%h required=%h", rd_data, m_rd_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // One tile of BEATS beats, element re = e, im = tag.
    task automatic write_tile(input int tag, input bit last, input bit last_b0, input bit rel_final);
        for (int b = 0; b < BEATS; b++) begin
            wr_valid = 1'b1;
            wr_last  = (b == BEATS - 1) ? last : last_b0;
            rd_release = (b == BEATS - 1) ? rel_final : 1'b0;
            for (int l = 0; l < WL; l++) begin
                wr_data[l].re = 16'(b*WL + l);
                wr_data[l].im = 16'(tag);
            end
            tick();
        end
        wr_valid = 1'b0; wr_last = 1'b0; rd_release = 1'b0;
    endtask

    task automatic read_tile(input int addr);
        rd_en = 1'b1; rd_addr = DB'(addr);
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
        b_reset = 1'b1; b_wr_valid = 1'b0; b_wr_last = 1'b0; b_wr_data = '0;
        b_rd_en = 1'b0; b_rd_addr = '0; b_rd_release = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_rd_bank_ready", 64'(rd_bank_ready), 64'd0);
        chk("rst_rd_tiles", 64'(rd_tiles), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(|rd_data), 64'd0);

        // Two-tile frame; wr_last on a non-final beat must be ignored.
        write_tile(0, 1'b0, 1'b1, 1'b0);
        chk("nonfinal_last_ignored", 64'(rd_bank_ready), 64'd0);
        write_tile(1, 1'b1, 1'b0, 1'b0);
        chk("commit_ready", 64'(rd_bank_ready), 64'd1);
        chk("commit_tiles", 64'(rd_tiles), 64'd2);
        read_tile(0);
        read_tile(1);
        chk("read1_valid", 64'(rd_valid), 64'd1);
        chk("read1_elem_2_1", 64'(rd_data[2][1]), 64'h0009_0001);

        // Out-of-range address: no valid, data held.
        read_tile(2);
        chk("oob_valid", 64'(rd_valid), 64'd0);
        chk("oob_hold", 64'(rd_data[2][1]), 64'h0009_0001);

        // Read and release together: served from the released bank.
        rd_release = 1'b1;
        read_tile(0);
        rd_release = 1'b0;
        chk("relrd_valid", 64'(rd_valid), 64'd1);
        chk("relrd_elem_0_3", 64'(rd_data[0][3]), 64'h0003_0000);
        chk("relrd_bank_ready", 64'(rd_bank_ready), 64'd0);

        // No committed frame: read refused.
        read_tile(0);
        chk("empty_valid", 64'(rd_valid), 64'd0);
        chk("empty_hold", 64'(rd_data[0][3]), 64'h0003_0000);

        // Fill bank 1 to capacity without wr_last.
        for (int t = 0; t < CAP; t++) write_tile(t, 1'b0, 1'b0, 1'b0);
        chk("cap_tiles", 64'(rd_tiles), 64'd512);
        chk("cap_ready", 64'(rd_bank_ready), 64'd1);
        write_tile(600, 1'b0, 1'b0, 1'b0);
        write_tile(601, 1'b0, 1'b0, 1'b0);
        write_tile(602, 1'b1, 1'b0, 1'b0);
        chk("stall_wr_ready", 64'(wr_ready), 64'd0);
        wr_valid = 1'b1;
        for (int l = 0; l < WL; l++) wr_data[l] = 32'hDEAD_BEEF;
        tick(); tick();
        chk("stall_still", 64'(wr_ready), 64'd0);
        wr_valid = 1'b0;
        read_tile(511);
        chk("cap_elem_3_3", 64'(rd_data[3][3]), 64'h000F_01FF);

        // Release unblocks the stalled writer next cycle.
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        chk("release_wr_ready", 64'(wr_ready), 64'd1);
        chk("release_tiles", 64'(rd_tiles), 64'd3);
        read_tile(2);
        chk("bank0_elem_0_0", 64'(rd_data[0][0]), 64'h0000_025A);

        // Commit bank 1 while releasing bank 0 in the same cycle.
        write_tile(700, 1'b1, 1'b0, 1'b1);
        chk("cr_wr_ready", 64'(wr_ready), 64'd1);
        chk("cr_rd_ready", 64'(rd_bank_ready), 64'd1);
        chk("cr_tiles", 64'(rd_tiles), 64'd1);
        read_tile(0);
        chk("cr_elem_1_1", 64'(rd_data[1][1]), 64'h0005_02BC);

        // Reset after the first beat of a tile.
        wr_valid = 1'b1; wr_last = 1'b0;
        for (int l = 0; l < WL; l++) wr_data[l] = 32'h1111_2222;
        tick();
        wr_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_wr_ready", 64'(wr_ready), 64'd1);
        chk("mrst_rd_bank_ready", 64'(rd_bank_ready), 64'd0);
        chk("mrst_rd_tiles", 64'(rd_tiles), 64'd0);
        chk("mrst_rd_valid", 64'(rd_valid), 64'd0);
        chk("mrst_rd_data", 64'(|rd_data), 64'd0);
        write_tile(77, 1'b1, 1'b0, 1'b0);
        chk("fresh_tiles", 64'(rd_tiles), 64'd1);
        chk("fresh_ready", 64'(rd_bank_ready), 64'd1);
        read_tile(0);
        chk("fresh_elem_1_2", 64'(rd_data[1][2]), 64'h0006_004D);
        chk("fresh_elem_0_0", 64'(rd_data[0][0]), 64'h0000_004D);

        // Wide instance: 4 beats of 16 lanes per 8x8 tile.
        b_reset = 1'b0;
        tick();
        chk("wide_rst_ready", 64'(b_wr_ready), 64'd1);
        chk("wide_rst_tiles", 64'(b_rd_tiles), 64'd0);
        for (int b = 0; b < 4; b++) begin
            b_wr_valid = 1'b1;
            b_wr_last  = (b == 3 || b == 1);
            for (int l = 0; l < WL2; l++) begin
                b_wr_data[l].re = 16'(b*WL2 + l);
                b_wr_data[l].im = 16'd5;
            end
            if (b == 2) chk("wide_no_early_commit", 64'(b_rd_bank_ready), 64'd0);
            tick();
        end
        b_wr_valid = 1'b0; b_wr_last = 1'b0;
        chk("wide_tiles", 64'(b_rd_tiles), 64'd1);
        chk("wide_ready", 64'(b_rd_bank_ready), 64'd1);
        b_rd_en = 1'b1; b_rd_addr = '0;
        tick();
        b_rd_en = 1'b0;
        chk("wide_valid", 64'(b_rd_valid), 64'd1);
        chk("wide_elem_4_5", 64'(b_rd_data[4][5]), 64'h0025_0005);
        chk("wide_elem_7_7", 64'(b_rd_data[7][7]), 64'h003F_0005);
        chk("wide_elem_1_0", 64'(b_rd_data[1][0]), 64'h0008_0005);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
